stopwatch_seq: RTL and testbench

//   Run-control sequencer for the 4-digit BCD stopwatch count (MM.SS style: d3 d2 . d1 d0).

---
 rtl/stopwatch_seq.sv | 165 ++++++++++++++++
 tb/tb_stopwatch_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_seq.sv
// Run-control sequencer for a 4-digit BCD stopwatch (d3 d2 . d1 d0).
// Debounces the start/stop button, owns the count-step prescaler, and runs
// the IDLE/RUN/PAUSE/DONE control that loads, steps and stops the count.
module stopwatch_seq #(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        b,
  input  logic [3:0]  LSB,
  input  logic [3:0]  MSB,
  input  logic [1:0]  mode,
  output logic [15:0] count,
  output logic        running,
  output logic        done
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    sync;
  logic          db_level;
  logic [DW-1:0] db_cnt;
  logic          press;

  logic [1:0]    state, state_n;
  logic [15:0]   count_n;
  logic [PW-1:0] presc, presc_n;
  logic          dir_down, dir_down_n;

  logic          tick_c;
  logic [15:0]   reload_c;
  logic [15:0]   limit_c;
  logic [15:0]   step_c;

  // Saturate a preset digit to a legal BCD value.
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // One BCD step up or down with decimal carry/borrow through all digits.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (up) begin
          if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
          else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Button synchronizer, debouncer and rising-level press pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= 2'b00;
      db_level <= 1'b0;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      sync  <= {sync[0], b};
      press <= 1'b0;
      if (sync[1] == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= sync[1];
        db_cnt   <= '0;
        press    <= sync[1];
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // Start value and terminal value for the selected direction.
  always_comb begin
    reload_c = {clamp9(MSB), clamp9(LSB), 8'h00};
    case (mode)
      2'b00:   reload_c = 16'h0000;
      2'b10:   reload_c = 16'h9999;
      default: reload_c = {clamp9(MSB), clamp9(LSB), 8'h00};
    endcase
    limit_c = dir_down ? 16'h0000 : 16'h9999;
    step_c  = bcd_step(count, !dir_down);
    tick_c  = (state == S_RUN) && (presc == PRE_LAST);
  end

  // Next-state, count and prescaler logic.
  always_comb begin
    state_n    = state;
    count_n    = count;
    presc_n    = presc;
    dir_down_n = dir_down;
    case (state)
      S_IDLE: begin
        count_n    = reload_c;
        dir_down_n = mode[1];
        presc_n    = '0;
        if (press) state_n = S_RUN;
      end
      S_RUN: begin
        presc_n = tick_c ? '0 : presc + PW'(1);
        if (press) state_n = S_PAUSE;
        if (tick_c) begin
          // A run started at its limit stops on the first tick without wrapping.
          if (count == limit_c) begin
            state_n = S_DONE;
          end else begin
            count_n = step_c;
            if (step_c == limit_c) state_n = S_DONE;
          end
        end
      end
      S_PAUSE: begin
        if (press) state_n = S_RUN;
      end
      default: begin
        presc_n = '0;
        if (press) state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status decodes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      count    <= 16'h0000;
      presc    <= '0;
      dir_down <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      presc    <= presc_n;
      dir_down <= dir_down_n;
      running  <= (state_n == S_RUN);
      done     <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_stopwatch_seq.sv
// Self-checking bench for stopwatch_seq with a short prescaler and debounce.
module tb_stopwatch_seq;

  localparam int unsigned TD = 4;
  localparam int unsigned DB = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        b     = 1'b0;
  logic [3:0]  LSB   = 4'd0;
  logic [3:0]  MSB   = 4'd0;
  logic [1:0]  mode  = 2'b00;
  logic [15:0] count;
  logic        running;
  logic        done;

  stopwatch_seq #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .b(b), .LSB(LSB), .MSB(MSB), .mode(mode),
    .count(count), .running(running), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] count;
    logic        running;
    logic        done;
  } exp_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [3:0]  msb;
    logic [3:0]  lsb;
    logic [15:0] exp_count;
  } vec_t;

  exp_t  sb[$];
  string sb_name[$];
  vec_t  tbl[8];
  int    checks   = 0;
  int    failures = 0;

  // Queue an expected output triple.
  task automatic expect_out(input string nm, input logic [15:0] c, input logic r, input logic d);
    exp_t e;
    e.count   = c;
    e.running = r;
    e.done    = d;
    sb.push_back(e);
    sb_name.push_back(nm);
  endtask

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic compare();
    exp_t  e;
    string nm;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e  = sb.pop_front();
    nm = sb_name.pop_front();
    if (count !== e.count || running !== e.running || done !== e.done) begin
      failures++;
      $display("FAIL %s: got count=%h running=%b done=%b, want count=%h running=%b done=%b",
               nm, count, running, done, e.count, e.running, e.done);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] c, input logic r, input logic d);
    expect_out(nm, c, r, d);
    compare();
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Clean button press from a falling edge; returns at the falling edge after the
  // rising edge on which the sequencer acts on the press (5th rising edge).
  task automatic press();
    b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    b = 1'b0;
  endtask

  // Async reset with an immediate output check, then release and check the IDLE reload.
  task automatic do_reset(input string nm, input logic [15:0] idle_exp);
    reset = 1'b0;
    #1;
    chk({nm, "_in_reset"}, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    cyc(2);
    chk({nm, "_idle"}, idle_exp, 1'b0, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{mode: 2'b00, msb: 4'd5, lsb: 4'd5, exp_count: 16'h0000};
    tbl[1] = '{mode: 2'b01, msb: 4'd1, lsb: 4'd1, exp_count: 16'h1100};
    tbl[2] = '{mode: 2'b10, msb: 4'd3, lsb: 4'd4, exp_count: 16'h9999};
    tbl[3] = '{mode: 2'b11, msb: 4'd2, lsb: 4'd7, exp_count: 16'h2700};
    tbl[4] = '{mode: 2'b00, msb: 4'hC, lsb: 4'hF, exp_count: 16'h0000};
    tbl[5] = '{mode: 2'b01, msb: 4'hC, lsb: 4'hF, exp_count: 16'h9900};
    tbl[6] = '{mode: 2'b11, msb: 4'hA, lsb: 4'd3, exp_count: 16'h9300};
    tbl[7] = '{mode: 2'b01, msb: 4'd0, lsb: 4'hB, exp_count: 16'h0900};

    @(negedge clk);

    // 1: count up from zero; mode/preset changes while running are ignored.
    mode = 2'b00; MSB = 4'd0; LSB = 4'd0;
    do_reset("t1", 16'h0000);
    press();
    chk("t1_start", 16'h0000, 1'b1, 1'b0);
    mode = 2'b11; MSB = 4'd5; LSB = 4'd5;
    cyc(40);
    chk("t1_40clk", 16'h0010, 1'b1, 1'b0);

    // 2: preset start, pause freezes count and prescaler, resume continues.
    mode = 2'b01; MSB = 4'd1; LSB = 4'd1;
    do_reset("t2", 16'h1100);
    press();
    chk("t2_start", 16'h1100, 1'b1, 1'b0);
    cyc(16);
    chk("t2_16clk", 16'h1104, 1'b1, 1'b0);
    press();
    chk("t2_pause", 16'h1105, 1'b0, 1'b0);
    cyc(20);
    chk("t2_paused20", 16'h1105, 1'b0, 1'b0);
    press();
    chk("t2_resume", 16'h1105, 1'b1, 1'b0);
    cyc(2);
    chk("t2_presc_held", 16'h1105, 1'b1, 1'b0);
    cyc(1);
    chk("t2_resume_tick", 16'h1106, 1'b1, 1'b0);

    // 3: full count down from 9999 to DONE, then back to IDLE.
    mode = 2'b10;
    do_reset("t3", 16'h9999);
    press();
    cyc(39995);
    chk("t3_before_limit", 16'h0001, 1'b1, 1'b0);
    cyc(1);
    chk("t3_done", 16'h0000, 1'b0, 1'b1);
    cyc(10);
    chk("t3_done_hold", 16'h0000, 1'b0, 1'b1);
    press();
    chk("t3_to_idle", 16'h0000, 1'b0, 1'b0);
    cyc(1);
    chk("t3_reload", 16'h9999, 1'b0, 1'b0);

    // 4: count up from 9900 to the 9999 limit, then the IDLE reload table.
    mode = 2'b01; MSB = 4'd9; LSB = 4'd9;
    do_reset("t4", 16'h9900);
    press();
    cyc(395);
    chk("t4_before_limit", 16'h9998, 1'b1, 1'b0);
    cyc(1);
    chk("t4_done", 16'h9999, 1'b0, 1'b1);
    press();
    chk("t4_to_idle", 16'h9999, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].mode;
      MSB  = tbl[i].msb;
      LSB  = tbl[i].lsb;
      expect_out($sformatf("tbl%0d", i), tbl[i].exp_count, 1'b0, 1'b0);
      cyc(1);
      compare();
    end

    // 5: short glitch ignored; press coinciding with a tick steps then pauses.
    mode = 2'b00; MSB = 4'd0; LSB = 4'd0;
    do_reset("t5", 16'h0000);
    b = 1'b1;
    @(negedge clk);
    b = 1'b0;
    cyc(8);
    chk("t5_glitch", 16'h0000, 1'b0, 1'b0);
    press();
    chk("t5_start", 16'h0000, 1'b1, 1'b0);
    repeat (7) @(negedge clk);
    press();
    chk("t5_press_tick", 16'h0003, 1'b0, 1'b0);
    cyc(8);
    chk("t5_paused", 16'h0003, 1'b0, 1'b0);

    // 5b: down from 0000 is already at the limit; first tick forces DONE.
    mode = 2'b11; MSB = 4'd0; LSB = 4'd0;
    do_reset("t5b", 16'h0000);
    press();
    cyc(3);
    chk("t5b_pre_tick", 16'h0000, 1'b1, 1'b0);
    cyc(1);
    chk("t5b_done", 16'h0000, 1'b0, 1'b1);

    // 6: async reset in the middle of a run, then reload per new mode.
    mode = 2'b00;
    do_reset("t6", 16'h0000);
    press();
    cyc(148);
    chk("t6_0037", 16'h0037, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    chk("t6_async_reset", 16'h0000, 1'b0, 1'b0);
    mode = 2'b11; MSB = 4'd4; LSB = 4'd2;
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk("t6_reload", 16'h4200, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
